// File: rtl/uart_dbg_cmd_rx.sv
// Debug command receiver: 8N1 UART bytes -> 0xA5-framed commands driving CPU halt/step and
// instruction-memory writes.
//   bit FSM   | meaning                     frame FSM    | meaning
//   B_IDLE    | wait for falling edge       F_HUNT       | wait for 0xA5 sync byte
//   B_START   | confirm start at mid-bit    F_CMD/F_ADDR | command / address byte
//   B_DATA    | shift in 8 bits, LSB first  F_D0..F_D3   | data bytes, little-endian
//   B_STOP    | check stop bit              F_CK         | XOR checksum, decode on match
module uart_dbg_cmd_rx #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD          = 115200,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx,
    output logic        halt_o,
    output logic        step_o,
    output logic        im_we_o,
    output logic [31:0] im_addr_o,
    output logic [31:0] im_data_o,
    output logic        cmd_valid_o,
    output logic [7:0]  cmd_o,
    output logic        frame_err_o,
    output logic        timeout_err_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int GAP_TICKS    = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int GW           = $clog2(GAP_TICKS + 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_TICKS);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
    typedef enum logic [2:0] {F_HUNT, F_CMD, F_ADDR, F_D0, F_D1, F_D2, F_D3, F_CK} frame_state_t;

    logic         rx_meta, rx_sync, rx_prev;
    bit_state_t   bit_state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]   bit_idx;
    logic [7:0]   rx_byte;
    logic         byte_done, byte_err;

    frame_state_t frame_state;
    logic [7:0]   cmd_r, addr_r, ck_acc;
    logic [31:0]  data_r;
    logic [GW-1:0] gap_cnt;

    // rx_prev is one flop behind rx_sync and only used for falling-edge detect
    always_ff @(posedge clk) begin
        if (resetn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            bit_state <= B_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            rx_byte   <= '0;
            byte_done <= 1'b0;
            byte_err  <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            byte_err  <= 1'b0;
            case (bit_state)
                B_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        bit_state <= B_START;
                        baud_cnt  <= HALF_LOAD;
                    end
                end
                B_START: begin
                    if (baud_cnt == '0) begin
                        if (!rx_sync) begin
                            bit_state <= B_DATA;
                            baud_cnt  <= FULL_LOAD;
                            bit_idx   <= '0;
                        end else begin
                            bit_state <= B_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                B_DATA: begin
                    if (baud_cnt == '0) begin
                        rx_byte  <= {rx_sync, rx_byte[7:1]};
                        baud_cnt <= FULL_LOAD;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            bit_state <= B_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                B_STOP: begin
                    if (baud_cnt == '0) begin
                        bit_state <= B_IDLE;
                        if (rx_sync)
                            byte_done <= 1'b1;
                        else
                            byte_err  <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    // Byte events take precedence over the gap timer, so error pulses stay mutually exclusive
    always_ff @(posedge clk) begin
        if (resetn) begin
            frame_state   <= F_HUNT;
            cmd_r         <= '0;
            addr_r        <= '0;
            ck_acc        <= '0;
            data_r        <= '0;
            gap_cnt       <= GAP_LOAD;
            halt_o        <= 1'b0;
            step_o        <= 1'b0;
            im_we_o       <= 1'b0;
            im_addr_o     <= '0;
            im_data_o     <= '0;
            cmd_valid_o   <= 1'b0;
            cmd_o         <= '0;
            frame_err_o   <= 1'b0;
            timeout_err_o <= 1'b0;
        end else begin
            step_o        <= 1'b0;
            im_we_o       <= 1'b0;
            cmd_valid_o   <= 1'b0;
            frame_err_o   <= 1'b0;
            timeout_err_o <= 1'b0;
            if (byte_err) begin
                frame_err_o <= 1'b1;
                frame_state <= F_HUNT;
                gap_cnt     <= GAP_LOAD;
            end else if (byte_done) begin
                gap_cnt <= GAP_LOAD;
                case (frame_state)
                    F_HUNT: begin
                        if (rx_byte == 8'hA5)
                            frame_state <= F_CMD;
                    end
                    F_CMD: begin
                        cmd_r       <= rx_byte;
                        ck_acc      <= rx_byte;
                        frame_state <= F_ADDR;
                    end
                    F_ADDR: begin
                        addr_r      <= rx_byte;
                        ck_acc      <= ck_acc ^ rx_byte;
                        frame_state <= F_D0;
                    end
                    F_D0: begin
                        data_r[7:0] <= rx_byte;
                        ck_acc      <= ck_acc ^ rx_byte;
                        frame_state <= F_D1;
                    end
                    F_D1: begin
                        data_r[15:8] <= rx_byte;
                        ck_acc       <= ck_acc ^ rx_byte;
                        frame_state  <= F_D2;
                    end
                    F_D2: begin
                        data_r[23:16] <= rx_byte;
                        ck_acc        <= ck_acc ^ rx_byte;
                        frame_state   <= F_D3;
                    end
                    F_D3: begin
                        data_r[31:24] <= rx_byte;
                        ck_acc        <= ck_acc ^ rx_byte;
                        frame_state   <= F_CK;
                    end
                    F_CK: begin
                        frame_state <= F_HUNT;
                        if (rx_byte == ck_acc) begin
                            cmd_valid_o <= 1'b1;
                            cmd_o       <= cmd_r;
                            case (cmd_r)
                                8'h01: halt_o <= 1'b1;
                                8'h02: halt_o <= 1'b0;
                                8'h03: step_o <= halt_o;
                                8'h10: begin
                                    im_we_o   <= 1'b1;
                                    im_addr_o <= {22'b0, addr_r, 2'b00};
                                    im_data_o <= data_r;
                                end
                                default: ;
                            endcase
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end
                endcase
            end else if (frame_state != F_HUNT) begin
                if (gap_cnt == GW'(1)) begin
                    timeout_err_o <= 1'b1;
                    frame_state   <= F_HUNT;
                    gap_cnt       <= GAP_LOAD;
                end else begin
                    gap_cnt <= gap_cnt - GW'(1);
                end
            end else begin
                gap_cnt <= GAP_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_uart_dbg_cmd_rx.sv
// Bench for uart_dbg_cmd_rx at 10 clocks per bit: directed frame table, corner-case sequences,
// then random frames checked against a byte-level frame model.
module tb_uart_dbg_cmd_rx;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        rx = 1'b1;
    logic        halt_o, step_o, im_we_o, cmd_valid_o, frame_err_o, timeout_err_o;
    logic [31:0] im_addr_o, im_data_o;
    logic [7:0]  cmd_o;

    always #5 clk = ~clk;

    uart_dbg_cmd_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .TIMEOUT_BYTES(4)) dut (
        .clk(clk), .resetn(resetn), .rx(rx),
        .halt_o(halt_o), .step_o(step_o), .im_we_o(im_we_o),
        .im_addr_o(im_addr_o), .im_data_o(im_data_o),
        .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o),
        .frame_err_o(frame_err_o), .timeout_err_o(timeout_err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse monitor: counts events and flags overlapping or stretched pulses
    int n_valid = 0, n_ferr = 0, n_terr = 0, n_step = 0, n_we = 0, n_viol = 0;
    logic pv = 0, pf = 0, pt = 0, ps = 0, pw = 0;
    always @(negedge clk) begin
        if (cmd_valid_o)   n_valid <= n_valid + 1;
        if (frame_err_o)   n_ferr  <= n_ferr + 1;
        if (timeout_err_o) n_terr  <= n_terr + 1;
        if (step_o)        n_step  <= n_step + 1;
        if (im_we_o)       n_we    <= n_we + 1;
        if ((int'(cmd_valid_o) + int'(frame_err_o) + int'(timeout_err_o)) > 1 ||
            (cmd_valid_o && pv) || (frame_err_o && pf) || (timeout_err_o && pt) ||
            (step_o && ps) || (im_we_o && pw) ||
            ((step_o || im_we_o) && !cmd_valid_o))
            n_viol <= n_viol + 1;
        pv <= cmd_valid_o; pf <= frame_err_o; pt <= timeout_err_o; ps <= step_o; pw <= im_we_o;
    end

    // Byte-level reference model of the frame protocol
    int          m_idx = 0;
    logic [7:0]  m_buf [8];
    logic        m_halt = 0;
    int          e_valid = 0, e_ferr = 0, e_terr = 0, e_step = 0, e_we = 0;
    logic [7:0]  e_cmd = 0;
    logic [31:0] e_addr = 0, e_data = 0;

    task automatic model_byte(input logic [7:0] b, input logic stop);
        logic [7:0] x;
        if (!stop) begin
            e_ferr++;
            m_idx = 0;
        end else if (m_idx == 0) begin
            if (b == 8'hA5) m_idx = 1;
        end else begin
            m_buf[m_idx] = b;
            m_idx++;
            if (m_idx == 8) begin
                m_idx = 0;
                x = 8'h00;
                for (int i = 1; i <= 6; i++) x = x ^ m_buf[i];
                if (x != m_buf[7]) begin
                    e_ferr++;
                end else begin
                    e_valid++;
                    e_cmd = m_buf[1];
                    if (m_buf[1] == 8'h01) m_halt = 1;
                    if (m_buf[1] == 8'h02) m_halt = 0;
                    if (m_buf[1] == 8'h03 && m_halt) e_step++;
                    if (m_buf[1] == 8'h10) begin
                        e_we++;
                        e_addr = 32'(m_buf[2]) * 4;
                        e_data = {m_buf[6], m_buf[5], m_buf[4], m_buf[3]};
                    end
                end
            end
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_clks(10);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(10);
        end
        rx = stop;
        wait_clks(10);
        rx = 1'b1;
        wait_clks(4);
        model_byte(b, stop);
    endtask

    function automatic logic [7:0] ck_of(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d);
        return c ^ a ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
    endfunction

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d, input logic [7:0] ck);
        send_byte(8'hA5, 1'b1);
        send_byte(c, 1'b1);
        send_byte(a, 1'b1);
        send_byte(d[7:0], 1'b1);
        send_byte(d[15:8], 1'b1);
        send_byte(d[23:16], 1'b1);
        send_byte(d[31:24], 1'b1);
        send_byte(ck, 1'b1);
        wait_clks(20);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, n_valid, e_valid);
        check({tag, ".ferr"}, n_ferr, e_ferr);
        check({tag, ".terr"}, n_terr, e_terr);
        check({tag, ".step"}, n_step, e_step);
        check({tag, ".we"}, n_we, e_we);
        check({tag, ".halt"}, 32'(halt_o), 32'(m_halt));
        check({tag, ".cmd"}, 32'(cmd_o), 32'(e_cmd));
        check({tag, ".addr"}, im_addr_o, e_addr);
        check({tag, ".data"}, im_data_o, e_data);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  ck;
        int          d_valid, d_ferr, d_step, d_we;
        logic        halt;
        logic [7:0]  cmd_exp;
        logic [31:0] addr_exp, data_exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int b_valid, b_ferr, b_step, b_we, b_terr, cnt;
        logic [7:0] c, a, k, j;
        logic [31:0] d;

        vecs[0] = '{8'h01, 8'h00, 32'h0, 8'h01, 1, 0, 0, 0, 1'b1, 8'h01, 32'h0, 32'h0};
        vecs[1] = '{8'h03, 8'h00, 32'h0, 8'h03, 1, 0, 1, 0, 1'b1, 8'h03, 32'h0, 32'h0};
        vecs[2] = '{8'h02, 8'h00, 32'h0, 8'h02, 1, 0, 0, 0, 1'b0, 8'h02, 32'h0, 32'h0};
        vecs[3] = '{8'h03, 8'h00, 32'h0, 8'h03, 1, 0, 0, 0, 1'b0, 8'h03, 32'h0, 32'h0};
        vecs[4] = '{8'h10, 8'h07, 32'h12345678, 8'h1F, 1, 0, 0, 1, 1'b0, 8'h10, 32'h1C, 32'h12345678};
        vecs[5] = '{8'h10, 8'h07, 32'h12345678, 8'h3C, 0, 1, 0, 0, 1'b0, 8'h10, 32'h1C, 32'h12345678};
        vecs[6] = '{8'h10, 8'hA5, 32'hA5A5A5A5, 8'hB5, 1, 0, 0, 1, 1'b0, 8'h10, 32'h294, 32'hA5A5A5A5};
        vecs[7] = '{8'h55, 8'h00, 32'h0, 8'h55, 1, 0, 0, 0, 1'b0, 8'h55, 32'h294, 32'hA5A5A5A5};

        resetn = 1'b1;
        wait_clks(5);
        check("reset_outputs",
              {halt_o, step_o, im_we_o, cmd_valid_o, frame_err_o, timeout_err_o, cmd_o, 18'b0},
              32'h0);
        check("reset_addr", im_addr_o, 32'h0);
        check("reset_data", im_data_o, 32'h0);
        resetn = 1'b0;
        wait_clks(5);

        for (int i = 0; i < 8; i++) begin
            b_valid = n_valid; b_ferr = n_ferr; b_step = n_step; b_we = n_we;
            send_frame(vecs[i].cmd, vecs[i].addr, vecs[i].data, vecs[i].ck);
            check($sformatf("vec%0d.valid", i), n_valid - b_valid, vecs[i].d_valid);
            check($sformatf("vec%0d.ferr", i), n_ferr - b_ferr, vecs[i].d_ferr);
            check($sformatf("vec%0d.step", i), n_step - b_step, vecs[i].d_step);
            check($sformatf("vec%0d.we", i), n_we - b_we, vecs[i].d_we);
            check($sformatf("vec%0d.halt", i), 32'(halt_o), 32'(vecs[i].halt));
            check($sformatf("vec%0d.cmd", i), 32'(cmd_o), 32'(vecs[i].cmd_exp));
            check($sformatf("vec%0d.addr", i), im_addr_o, vecs[i].addr_exp);
            check($sformatf("vec%0d.data", i), im_data_o, vecs[i].data_exp);
        end

        // Stop-bit error on an idle line
        b_valid = n_valid; b_ferr = n_ferr;
        send_byte(8'h55, 1'b0);
        wait_clks(10);
        check("stop_err.ferr", n_ferr - b_ferr, 1);
        check("stop_err.valid", n_valid - b_valid, 0);

        // Short low glitch must not start a byte
        b_valid = n_valid; b_ferr = n_ferr;
        rx = 1'b0;
        wait_clks(3);
        rx = 1'b1;
        wait_clks(200);
        check("glitch.ferr", n_ferr - b_ferr, 0);
        check("glitch.valid", n_valid - b_valid, 0);

        // Partial frame abandoned by the gap timer
        b_terr = n_terr;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h07, 1'b1);
        cnt = 0;
        while (n_terr == b_terr && cnt < 700) begin
            wait_clks(1);
            cnt++;
        end
        check("timeout.fired", n_terr - b_terr, 1);
        check("timeout.latency_ok", 32'(cnt >= 393 && cnt <= 399), 32'd1);
        e_terr++;
        m_idx = 0;
        wait_clks(10);

        b_valid = n_valid;
        send_frame(8'h01, 8'h00, 32'h0, 8'h01);
        check("after_timeout.valid", n_valid - b_valid, 1);
        check("after_timeout.halt", 32'(halt_o), 32'd1);
        check_model("pre_reset");

        // Reset in the middle of a byte inside a frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b1);
        rx = 1'b0;
        wait_clks(35);
        resetn = 1'b1;
        rx = 1'b1;
        wait_clks(3);
        check("midreset.halt", 32'(halt_o), 32'd0);
        check("midreset.flags",
              {step_o, im_we_o, cmd_valid_o, frame_err_o, timeout_err_o, cmd_o, 19'b0}, 32'h0);
        check("midreset.addr", im_addr_o, 32'h0);
        check("midreset.data", im_data_o, 32'h0);
        resetn = 1'b0;
        m_idx = 0; m_halt = 0; e_cmd = 0; e_addr = 0; e_data = 0;
        wait_clks(10);
        send_frame(8'h10, 8'h3F, 32'hCAFEF00D, ck_of(8'h10, 8'h3F, 32'hCAFEF00D));
        check_model("post_reset");

        // Random traffic against the frame model
        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 9))
                0: begin
                    j = 8'($urandom);
                    if (j == 8'hA5) j = 8'h00;
                    send_byte(j, 1'b1);
                end
                1: begin
                    send_byte(8'hA5, 1'b1);
                    cnt = $urandom_range(0, 5);
                    for (int i = 0; i < cnt; i++) send_byte(8'($urandom), 1'b1);
                    send_byte(8'($urandom), 1'b0);
                    wait_clks(20);
                end
                default: begin
                    case ($urandom_range(0, 4))
                        0: c = 8'h01;
                        1: c = 8'h02;
                        2: c = 8'h03;
                        3: c = 8'h10;
                        default: c = 8'($urandom);
                    endcase
                    a = 8'($urandom);
                    d = $urandom;
                    k = ck_of(c, a, d);
                    if ($urandom_range(0, 4) == 0) k = k ^ (8'd1 << $urandom_range(0, 7));
                    send_frame(c, a, d, k);
                end
            endcase
            check_model($sformatf("rand%0d", it));
        end

        check("pulse_rules", n_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
